// File: rtl/ram_ws_pkg.sv
// ram_ws_pkg
// Shared types and helpers for the wait-state RAM slice.
//   state_t          : FSM states of the transaction controller
//   strb_width(dw)   : number of byte lanes in a dw-bit word
//   lane_bits(dw)    : number of byte-offset address bits inside a word
package ram_ws_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ram_ws_if.sv
// ram_ws_if
// CPU native memory bus as seen by the wait-state RAM.
//   valid  : request valid, held by the master until ready
//   addr   : byte address
//   din    : write data
//   wstrb  : byte-lane write enables, all-zero means read
//   dout   : registered read data
//   ready  : one-cycle completion pulse
//   err    : out-of-range completion flag, pulses with ready
//   busy   : high from acceptance to the end of the ready cycle
// Modports: master (CPU side), slave (RAM side).
interface ram_ws_if
    import ram_ws_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                              valid;
    logic [31:0]                       addr;
    logic [DATA_WIDTH-1:0]             din;
    logic [strb_width(DATA_WIDTH)-1:0] wstrb;
    logic [DATA_WIDTH-1:0]             dout;
    logic                              ready;
    logic                              err;
    logic                              busy;

    modport master (
        output valid, addr, din, wstrb,
        input  dout, ready, err, busy
    );

    modport slave (
        input  valid, addr, din, wstrb,
        output dout, ready, err, busy
    );
endinterface

// File: rtl/ram_ws_array.sv
// ram_ws_array
// Word storage with byte-lane writes and a registered read port.
// Contents are deliberately not reset.
//   clk    : clock
//   we     : write enable (lanes selected by be)
//   be     : per-lane byte enables
//   idx    : word index
//   wdata  : write data
//   rd_en  : load rdata from mem[idx] on this edge
//   rdata  : registered read data, holds between reads
module ram_ws_array
    import ram_ws_pkg::*;
#(
    parameter int IDX_BITS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [STRB_WIDTH-1:0] be,
    input  logic [IDX_BITS-1:0]   idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(1 << IDX_BITS)-1];

    // Lane-masked write and registered read share one port; the controller
    // never asserts both in the same cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/ram_ws.sv
// ram_ws
// Word-addressed SoC RAM with byte-lane write strobes and configurable
// read/write wait states, terminated by a registered one-cycle ready pulse.
//   clk    : clock
//   resetn : synchronous active-low reset (aborts any transaction in flight)
//   bus    : ram_ws_if.slave (valid/addr/din/wstrb in, dout/ready/err/busy out)
// Optional feature macro RAM_WS_BOUNDS_CHECK_EN: when defined, addresses
// outside [BASE_ADDR, BASE_ADDR + 2**ADDR_BITS) complete with err=1, writes
// are dropped and reads return 0. When undefined the address aliases into
// the array and err is tied low.
module ram_ws
    import ram_ws_pkg::*;
#(
    parameter int          ADDR_BITS  = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          READ_WAIT  = 1,
    parameter int          WRITE_WAIT = 0
) (
    input logic     clk,
    input logic     resetn,
    ram_ws_if.slave bus
);
    localparam int SW   = strb_width(DATA_WIDTH);
    localparam int LB   = lane_bits(DATA_WIDTH);
    localparam int IW   = ADDR_BITS - LB;
    localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CW   = (MAXW > 0) ? $clog2(MAXW + 1) : 1;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           offset;
    logic [IW-1:0]         live_idx, idx_q, req_idx;
    logic [DATA_WIDTH-1:0] din_q, req_din, rdata;
    logic [SW-1:0]         wstrb_q, req_wstrb;
    logic                  live_oob, oob_q, req_oob;
    logic                  live_read, req_read, in_idle;
    logic                  commit, mem_we, mem_rd;
    logic                  ready_q, busy_q, dout_clr;
    logic                  unused_offset;
    int                    live_wait;

    assign offset        = bus.addr - BASE_ADDR;
    assign live_idx      = offset[ADDR_BITS-1:LB];
    assign unused_offset = ^offset;
    assign live_read     = (bus.wstrb == '0);
    assign live_wait     = live_read ? READ_WAIT : WRITE_WAIT;

`ifdef RAM_WS_BOUNDS_CHECK_EN
    localparam logic [32:0] WINDOW = 33'(1) << ADDR_BITS;
    assign live_oob = (bus.addr < BASE_ADDR) || ({1'b0, offset} >= WINDOW);
`else
    assign live_oob = 1'b0;
`endif

    // With zero wait states the commit happens on the acceptance edge itself,
    // before anything is latched, so the request comes straight from the bus.
    assign in_idle   = (state_q == IDLE);
    assign req_idx   = in_idle ? live_idx  : idx_q;
    assign req_din   = in_idle ? bus.din   : din_q;
    assign req_wstrb = in_idle ? bus.wstrb : wstrb_q;
    assign req_oob   = in_idle ? live_oob  : oob_q;
    assign req_read  = (req_wstrb == '0);

    // Commit is the edge that enters RESP; a reset on that edge discards it.
    assign commit = resetn && (state_d == RESP);
    assign mem_we = commit && !req_read && !req_oob;
    assign mem_rd = commit &&  req_read && !req_oob;

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    if (live_wait == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(live_wait - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs.
    // dout_clr forces dout to zero after reset and after an out-of-range read,
    // so the unreset array output never reaches the bus.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            dout_clr <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RESP);
            busy_q  <= (state_d != IDLE);
            if (commit && req_read) begin
                dout_clr <= req_oob;
            end
        end
    end

    // Request capture on acceptance; no reset needed, only read after a
    // valid acceptance.
    always_ff @(posedge clk) begin
        if (in_idle && bus.valid) begin
            idx_q   <= live_idx;
            din_q   <= bus.din;
            wstrb_q <= bus.wstrb;
            oob_q   <= live_oob;
        end
    end

`ifdef RAM_WS_BOUNDS_CHECK_EN
    logic err_q;

    // err pulses alongside ready for an out-of-range transaction.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= commit && req_oob;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.dout  = dout_clr ? '0 : rdata;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

    ram_ws_array #(
        .IDX_BITS   (IW),
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (SW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (req_wstrb),
        .idx   (req_idx),
        .wdata (req_din),
        .rd_en (mem_rd),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_ram_ws.sv
// tb_ram_ws
// Scoreboard bench for ram_ws. Two instances:
//   dut_a : BASE 0x0000, READ_WAIT=1, WRITE_WAIT=0
//   dut_b : BASE 0x1000, READ_WAIT=3, WRITE_WAIT=2
// The driver pushes the expected completion (ready cycle, dout, err) when a
// request is accepted; the negedge monitor pops and compares on every ready.
// Out-of-range cases run only when RAM_WS_BOUNDS_CHECK_EN is defined.
module tb_ram_ws;
    import ram_ws_pkg::*;

    localparam int RW_A = 1;
    localparam int WW_A = 0;
    localparam int RW_B = 3;
    localparam int WW_B = 2;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        int          cyc;
    } sb_t;

    logic        clk;
    logic        resetn_a, resetn_b;
    int          cyc;
    int          checks;
    int          errors;
    logic [31:0] last_a, last_b;
    sb_t         sb_a[$];
    sb_t         sb_b[$];
    int          rdy_times_b[$];

    ram_ws_if #(.DATA_WIDTH(32)) ifa ();
    ram_ws_if #(.DATA_WIDTH(32)) ifb ();

    ram_ws #(
        .ADDR_BITS(10), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_0000),
        .READ_WAIT(RW_A), .WRITE_WAIT(WW_A)
    ) dut_a (
        .clk(clk), .resetn(resetn_a), .bus(ifa)
    );

    ram_ws #(
        .ADDR_BITS(10), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_1000),
        .READ_WAIT(RW_B), .WRITE_WAIT(WW_B)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pops the oldest expectation for a DUT and compares its completion.
    task automatic checkReady(input int d, input logic [31:0] dv, input logic ev);
        sb_t e;
        if (d == 0) begin
            if (sb_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut0_unexpected_ready: got ready at cycle %0d, expected none", cyc);
                return;
            end
            e = sb_a.pop_front();
        end else begin
            if (sb_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut1_unexpected_ready: got ready at cycle %0d, expected none", cyc);
                return;
            end
            e = sb_b.pop_front();
            rdy_times_b.push_back(cyc);
        end
        checkOutput($sformatf("dut%0d_ready_cycle", d), cyc, e.cyc);
        checkOutput($sformatf("dut%0d_dout", d), dv, e.dout);
        checkOutput($sformatf("dut%0d_err", d), {31'b0, ev}, {31'b0, e.err});
    endtask

    // Monitor: every ready cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (ifa.ready === 1'b1) checkReady(0, ifa.dout, ifa.err);
        if (ifb.ready === 1'b1) checkReady(1, ifb.dout, ifb.err);
    end

    function automatic logic readyOf(input int d);
        return (d == 0) ? ifa.ready : ifb.ready;
    endfunction

    function automatic logic busyOf(input int d);
        return (d == 0) ? ifa.busy : ifb.busy;
    endfunction

    task automatic driveBus(input int d, input logic v, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
        if (d == 0) begin
            ifa.valid = v; ifa.addr = a; ifa.din = wd; ifa.wstrb = ws;
        end else begin
            ifb.valid = v; ifb.addr = a; ifb.din = wd; ifb.wstrb = ws;
        end
    endtask

    // Issues one request; pushes the expectation on acceptance. Expected
    // ready appears at the edge count acc+W (cycle k+W+1 after edge k).
    // hold keeps valid high after ready; abort resets the DUT one cycle
    // after acceptance and expects no completion.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic [31:0] exp_rd,
                                 input logic exp_err, input bit hold, input bit abort);
        int  w;
        int  acc;
        int  n;
        bit  ok;
        sb_t e;
        if (d == 0) w = (ws == 4'h0) ? RW_A : WW_A;
        else        w = (ws == 4'h0) ? RW_B : WW_B;
        driveBus(d, 1'b1, a, wd, ws);
        ok = 1'b0;
        for (n = 0; n < 20 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (busyOf(d) === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d_accept_timeout: got no busy, expected acceptance of %h", d, a);
            driveBus(d, 1'b0, a, wd, ws);
            return;
        end
        acc = cyc;
        if (abort) begin
            if (d == 0) resetn_a = 1'b0; else resetn_b = 1'b0;
            driveBus(d, 1'b0, a, wd, ws);
            @(posedge clk);
            #1;
            if (d == 0) begin resetn_a = 1'b1; last_a = 32'h0; end
            else        begin resetn_b = 1'b1; last_b = 32'h0; end
            checkOutput($sformatf("dut%0d_busy_after_abort", d), {31'b0, busyOf(d)}, 32'h0);
            checkOutput($sformatf("dut%0d_ready_after_abort", d), {31'b0, readyOf(d)}, 32'h0);
            return;
        end
        if (ws == 4'h0) begin
            if (d == 0) last_a = exp_rd; else last_b = exp_rd;
        end
        e.dout = (d == 0) ? last_a : last_b;
        e.err  = exp_err;
        e.cyc  = acc + w;
        if (d == 0) sb_a.push_back(e); else sb_b.push_back(e);
        n = 0;
        while (readyOf(d) !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (readyOf(d) !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d_ready_timeout: got no ready, expected one for %h", d, a);
        end
        if (!hold) driveBus(d, 1'b0, a, wd, ws);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        last_a   = 32'h0;
        last_b   = 32'h0;
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        driveBus(0, 1'b0, 32'h0, 32'h0, 4'h0);
        driveBus(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        resetn_a = 1'b1;
        resetn_b = 1'b1;

        $display("[TB] reset and idle");
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("idle_ready_a", {31'b0, ifa.ready}, 32'h0);
            checkOutput("idle_err_a",   {31'b0, ifa.err},   32'h0);
            checkOutput("idle_busy_a",  {31'b0, ifa.busy},  32'h0);
            checkOutput("idle_dout_a",  ifa.dout,           32'h0);
            checkOutput("idle_ready_b", {31'b0, ifb.ready}, 32'h0);
            checkOutput("idle_busy_b",  {31'b0, ifb.busy},  32'h0);
            checkOutput("idle_dout_b",  ifb.dout,           32'h0);
        end

        $display("[TB] full and partial writes, zero-wait write / one-wait read");
        applyStimulus(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0);
        applyStimulus(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 32'h10, 32'h11223344, 4'h5, 32'h0,        1'b0, 1'b0, 1'b0);
        applyStimulus(0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 32'h13, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 32'h3FC, 32'hA5A55A5A, 4'hF, 32'h0,       1'b0, 1'b0, 1'b0);
        applyStimulus(0, 32'h3FC, 32'h0,       4'h0, 32'hA5A55A5A, 1'b0, 1'b0, 1'b0);

        $display("[TB] back-to-back reads with valid held");
        applyStimulus(1, 32'h1000, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 32'h1004, 32'h600DCAFE, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
        rdy_times_b.delete();
        applyStimulus(1, 32'h1000, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, 32'h1004, 32'h0, 4'h0, 32'h600DCAFE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        if (rdy_times_b.size() == 2) begin
            checkOutput("b2b_ready_spacing", rdy_times_b[1] - rdy_times_b[0], 32'd5);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL b2b_ready_count: got %0d pulses, expected 2", rdy_times_b.size());
        end

        $display("[TB] reset during a waiting write");
        applyStimulus(1, 32'h1020, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 32'h1020, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(1, 32'h1020, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0, 1'b0);

`ifdef RAM_WS_BOUNDS_CHECK_EN
        $display("[TB] out-of-range accesses");
        applyStimulus(1, 32'h1400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 32'h1000, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 32'h0FFC, 32'h0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0);
        applyStimulus(1, 32'h1004, 32'h0, 4'h0, 32'h600DCAFE, 1'b0, 1'b0, 1'b0);
`endif

        repeat (10) @(posedge clk);
        #1;
        checkOutput("sb_a_drained", sb_a.size(), 32'h0);
        checkOutput("sb_b_drained", sb_b.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_ws.md
Name: ram_ws

Overview:
- Parametrised word-addressed SoC RAM with byte-lane write strobes and configurable read/write wait states.
- Sits on the CPU native memory bus (valid/ready, ready-terminated transactions) next to the existing single-cycle RAM.
- Used to model slower on-chip memories and to exercise CPU stall paths.
- Unlike the single-cycle RAM, output data and ready are registered and driven by a small FSM.

Parameters:
ADDR_BITS, 10, byte-address width of the window; capacity 2**ADDR_BITS bytes
DATA_WIDTH, 32, word width in bits; multiple of 8, >= 8
BASE_ADDR, 32'h0000_0000, window base; aligned to 2**ADDR_BITS
READ_WAIT, 1, extra cycles before ready on reads (0..15)
WRITE_WAIT, 0, extra cycles before ready on writes (0..15)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
valid  in  1  request valid; held by master until ready
addr  in  32  byte address
din  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte-lane write enables; all-zero means read
dout  out  DATA_WIDTH  registered read data
ready  out  1  one-cycle completion pulse
err  out  1  out-of-range completion flag; pulses with ready
busy  out  1  high from acceptance to end of ready cycle

Behaviour:
- Reset (resetn=0 at posedge):
  - state IDLE; ready=0, err=0, busy=0, dout=0, wait counter=0.
  - Array contents are not reset.
- Index computation:
  - LB = log2(DATA_WIDTH/8).
  - idx = (addr - BASE_ADDR)[ADDR_BITS-1:LB].
  - Low LB address bits are ignored.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Acceptance edge is a posedge with state=IDLE, valid=1, resetn=1.
  - On acceptance, latch idx, din and wstrb.
  - W = READ_WAIT if wstrb==0, else WRITE_WAIT.
  - W==0: go to RESP. W>0: go to WAIT with counter=W-1.
  - busy rises on the acceptance edge.
- WAIT:
  - Counter decrements each cycle.
  - Go to RESP on the edge where counter==0.
- RESP commit (edge entering RESP):
  - Write: array[idx] lanes with wstrb=1 take latched din; other lanes are unchanged.
  - Read: dout <= array[idx].
  - ready=1 for exactly the RESP cycle.
- RESP exit: next edge returns to IDLE with ready=0.
  - A valid already high in that IDLE cycle is accepted on the following edge.
  - Throughput is one transaction per W+2 cycles.
- Latency: ready is high in cycle k+W+1, where k is the acceptance edge.
- dout holds its value until the next read commit. Writes never change dout.
- valid is ignored in WAIT and RESP.
  - valid dropped mid-transaction is a protocol violation.
  - The block still completes: the write commits and ready pulses.
- Read-after-write to the same idx in back-to-back transactions returns the new data.
- Reset mid-transaction:
  - Transaction is aborted and no ready pulse is issued.
  - A write whose RESP edge has not yet occurred is discarded.
- Counter width: $clog2(max(READ_WAIT, WRITE_WAIT)+1), minimum 1.

Optional Feature:
- Macro: RAM_WS_BOUNDS_CHECK_EN.
- Defined:
  - Address is out of range if addr < BASE_ADDR or addr >= BASE_ADDR + 2**ADDR_BITS.
  - Out-of-range write: suppressed.
  - Out-of-range read: dout <= 0.
  - err=1 in the RESP cycle. Wait-state timing is unchanged.
- Undefined:
  - Address is truncated and aliases into the array.
  - err is tied 0.

Decomposition:
- Package ram_ws_pkg:
  - state enum (IDLE/WAIT/RESP)
  - function strb_width(DATA_WIDTH)
  - function lane_bits(DATA_WIDTH) returning LB
- Sub-module ram_ws_array:
  - Storage of 2**(ADDR_BITS-LB) words.
  - Inputs: we, per-lane byte enables, idx, wdata.
  - Registered read with an rd_en input. No reset.
- Top (ram_ws): FSM, counter, address check, err.

Test Plan:
- Reset, then idle with valid=0 for 5 cycles -> ready, err, busy all 0; dout=0.
- READ_WAIT=1, WRITE_WAIT=0:
  - Write addr 0x10, din 0xDEADBEEF, wstrb 4'hF -> ready in cycle k+1.
  - Read addr 0x10 -> ready in cycle k+2; dout=0xDEADBEEF.
- Partial write addr 0x10, din 0x11223344, wstrb 4'b0101, then read -> dout=0xDE22BE44.
- READ_WAIT=3, back-to-back reads of 0x0 and 0x4 with valid held high -> ready pulses exactly 5 cycles apart, each one cycle wide.
- WRITE_WAIT=2, resetn pulsed low one cycle after acceptance of a write of 0xCAFEF00D to 0x20 -> no ready; a later read of 0x20 returns the prior contents.
- RAM_WS_BOUNDS_CHECK_EN, BASE_ADDR=0x1000, ADDR_BITS=10:
  - Write to 0x1400 -> ready with err=1; array unchanged.
  - Read 0x0FFC -> dout=0, err=1.
